// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//
// Single-cycle style CPU datapath: program counter, instruction register,
// dual-read / single-write register file, combinational ALU and a data
// memory with a registered (one-cycle latency) read port. All sequencing is
// done by an external controller through the control inputs. Every piece of
// state updates on the same rising edge with no interlocks between them.
//
// Ports
//   Clk            clock, rising edge
//   Rst            synchronous active-high reset (PC, IR, register file, DMemQ)
//   PCClr          clear the PC
//   PCUp           increment the PC (wraps at 2^PC_W)
//   IRLd           load the IR from IData (fetched at the pre-edge PC)
//   IAddr          instruction memory address, always equal to the PC
//   IData          instruction memory read data (combinational from IAddr)
//   instruction    IR contents
//   DAddr          data memory address
//   DWrite         data memory write enable (writes RFAData)
//   RFSelect       register file write source: 1 = DMemQ, 0 = ALUOut
//   RFWriteAddr    register file write index
//   RFWriteEnable  register file write enable
//   RFAReadAddr    register file port A read index
//   RFBReadAddr    register file port B read index
//   ALUSelect      ALU operation code
//   RFAData        register file port A read data (ALU operand A)
//   RFBData        register file port B read data (ALU operand B)
//   ALUOut         ALU result
//   ALUZero        1 when ALUOut is zero
//   DMemQ          registered data memory read data
//   PCOut          PC value for debug
// ---------------------------------------------------------------------------
module cpu_datapath #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 256,
    parameter int RF_DEPTH   = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PCClr,
    input  logic              PCUp,
    input  logic              IRLd,
    output logic [PC_W-1:0]   IAddr,
    input  logic [DATA_W-1:0] IData,
    output logic [DATA_W-1:0] instruction,
    input  logic [7:0]        DAddr,
    input  logic              DWrite,
    input  logic              RFSelect,
    input  logic [3:0]        RFWriteAddr,
    input  logic              RFWriteEnable,
    input  logic [3:0]        RFAReadAddr,
    input  logic [3:0]        RFBReadAddr,
    input  logic [2:0]        ALUSelect,
    output logic [DATA_W-1:0] RFAData,
    output logic [DATA_W-1:0] RFBData,
    output logic [DATA_W-1:0] ALUOut,
    output logic              ALUZero,
    output logic [DATA_W-1:0] DMemQ,
    output logic [PC_W-1:0]   PCOut
);

    // ALU operation codes
    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;
    localparam logic [2:0] ALU_XOR    = 3'b101;
    localparam logic [2:0] ALU_NOT_A  = 3'b110;
    localparam logic [2:0] ALU_INC_A  = 3'b111;

    // ALU evaluation; all arithmetic wraps modulo 2^DATA_W, carry/borrow dropped
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        res = '0;
        case (op)
            ALU_PASS_A: res = a;
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_AND:    res = a & b;
            ALU_OR:     res = a | b;
            ALU_XOR:    res = a ^ b;
            ALU_NOT_A:  res = ~a;
            ALU_INC_A:  res = a + DATA_W'(1);
            default:    res = '0;
        endcase
        return res;
    endfunction

    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] rf_r   [RF_DEPTH];
    logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
    logic [DATA_W-1:0] dmemq_r;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] rf_wdata_s;

    // Program counter: reset, then clear, then increment, otherwise hold
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_r <= '0;
        end else if (PCClr) begin
            pc_r <= '0;
        end else if (PCUp) begin
            pc_r <= pc_r + PC_W'(1);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction register; IData reflects the pre-edge PC, so IRLd with
    // PCUp captures mem[PC] while the PC moves on to PC+1
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ir_r <= '0;
        end else if (IRLd) begin
            ir_r <= IData;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Register file write data selection
    always_comb begin
        rf_wdata_s = alu_s;
        if (RFSelect) begin
            rf_wdata_s = dmemq_r;
        end else begin
            rf_wdata_s = alu_s;
        end
    end

    // Register file storage; reads are asynchronous so a same-cycle write
    // is only visible after the edge (reads see the old value)
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_r[i] <= '0;
            end
        end else if (RFWriteEnable) begin
            rf_r[RFWriteAddr] <= rf_wdata_s;
        end
    end

    // Asynchronous register file read ports
    always_comb begin
        RFAData = rf_r[RFAReadAddr];
        RFBData = rf_r[RFBReadAddr];
    end

    // Combinational ALU and zero flag
    always_comb begin
        alu_s   = alu_f(ALUSelect, RFAData, RFBData);
        ALUOut  = alu_s;
        ALUZero = (alu_s == '0);
    end

    // Data memory array; contents survive reset and Rst blocks any write
    always_ff @(posedge Clk) begin
        if (!Rst && DWrite) begin
            dmem_r[DAddr] <= RFAData;
        end
    end

    // Registered data memory read; samples the array before this edge's
    // write lands, giving read-before-write on an address collision
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dmemq_r <= '0;
        end else begin
            dmemq_r <= dmem_r[DAddr];
        end
    end

    // Output mapping
    always_comb begin
        IAddr       = pc_r;
        PCOut       = pc_r;
        instruction = ir_r;
        DMemQ       = dmemq_r;
    end

endmodule
